// File: rtl/mac_rr_sched_pkg.sv
// Shared defaults and helpers for the round-robin MAC scheduler.
// Parameter defaults, pipeline field widths and the signed-add overflow helper.
package mac_rr_sched_pkg;

  localparam int MAC_N     = 4;
  localparam int MAC_IDW   = 2;
  localparam int MAC_ACC_W = 24;
  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;

  // Overflow when both addends share a sign that the sum does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/mult8x8.sv
// Combinational signed 8x8 radix-4 Booth multiplier with an exact 16-bit product.
// The sum is kept modulo 2^16, which is exact because every 8x8 signed product fits.
module mult8x8 (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);

  logic        [8:0]  b_ext;
  logic        [2:0]  trip;
  logic signed [15:0] a_ext;
  logic signed [15:0] pp;
  logic signed [15:0] sum;

  always_comb begin
    b_ext = {b, 1'b0};
    a_ext = {{8{a[7]}}, a};
    sum   = '0;
    trip  = '0;
    pp    = '0;
    for (int j = 0; j < 4; j++) begin
      trip = b_ext[2*j+2 -: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2*j));
    end
    p = sum;
  end

endmodule

// File: rtl/rr_arb_n.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping mod N.
// Outputs a one-hot grant and its encoded index; nothing is granted while en is low.
module rr_arb_n #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   vld,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && vld[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mac_rr_sched.sv
// Shares one mult8x8 among N requesters: round-robin issue, operand reg -> product reg ->
// per-requester signed accumulate, with a one-cycle response pulse per accumulator update.
module mac_rr_sched
  import mac_rr_sched_pkg::*;
#(
  parameter int N     = MAC_N,
  parameter int IDW   = MAC_IDW,
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           req_vld,
  input  logic [N*OP_W-1:0]      req_a,
  input  logic [N*OP_W-1:0]      req_b,
  input  logic [N-1:0]           req_clr,
  output logic [N-1:0]           req_rdy,
  output logic                   rsp_vld,
  output logic [IDW-1:0]         rsp_id,
  output logic signed [ACC_W-1:0] rsp_acc,
  output logic                   rsp_ovf,
  output logic                   busy
);

  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] ptr;
  logic           arb_en;

  logic                   s1_vld;
  logic [IDW-1:0]         s1_id;
  logic signed [OP_W-1:0] s1_a;
  logic signed [OP_W-1:0] s1_b;
  logic                   s1_clr;
  logic signed [PROD_W-1:0] mul_p;

  logic                     s2_vld;
  logic [IDW-1:0]           s2_id;
  logic                     s2_clr;
  logic signed [PROD_W-1:0] s2_prod;

  logic signed [ACC_W-1:0] acc [N];
  logic [N-1:0]            ovf;

  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    ovf_new;

  // Grants are suppressed during reset so nothing is accepted that the reset would drop.
  assign arb_en  = en & ~rst;
  assign req_rdy = gnt;
  assign busy    = s1_vld | s2_vld;

  rr_arb_n #(.N(N), .IDW(IDW)) u_arb (
    .vld (req_vld),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .id  (gnt_id)
  );

  mult8x8 u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
    acc_base = s2_clr ? '0 : acc[s2_id];
    acc_sum  = acc_base + prod_ext;
    ovf_new  = ~s2_clr & (ovf[s2_id] |
               add_ovf(acc_base[ACC_W-1], prod_ext[ACC_W-1], acc_sum[ACC_W-1]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      s1_vld  <= 1'b0;
      s1_id   <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_clr  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_id   <= '0;
      s2_clr  <= 1'b0;
      s2_prod <= '0;
      ovf     <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_acc <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      s1_vld <= |gnt;
      if (|gnt) begin
        s1_id  <= gnt_id;
        s1_a   <= req_a[OP_W*gnt_id +: OP_W];
        s1_b   <= req_b[OP_W*gnt_id +: OP_W];
        s1_clr <= req_clr[gnt_id];
        ptr    <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_id   <= s1_id;
        s2_clr  <= s1_clr;
        s2_prod <= mul_p;
      end

      // S2 is the only reader and writer of acc, so back-to-back ops on one id see fresh data.
      rsp_vld <= s2_vld;
      if (s2_vld) begin
        acc[s2_id] <= acc_sum;
        ovf[s2_id] <= ovf_new;
        rsp_id     <= s2_id;
        rsp_acc    <= acc_sum;
        rsp_ovf    <= ovf_new;
      end
    end
  end

endmodule

// File: tb/tb_mac_rr_sched.sv
// Bench for mac_rr_sched: directed scenarios plus random traffic against a queue-based model.
module tb_mac_rr_sched;

  localparam int NQ  = 4;
  localparam int IW  = 2;
  localparam int ACC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NQ-1:0]     req_vld;
  logic [NQ*8-1:0]   req_a;
  logic [NQ*8-1:0]   req_b;
  logic [NQ-1:0]     req_clr;
  logic [NQ-1:0]     req_rdy;
  logic              rsp_vld;
  logic [IW-1:0]     rsp_id;
  logic signed [ACC-1:0] rsp_acc;
  logic              rsp_ovf;
  logic              busy;

  mac_rr_sched #(.N(NQ), .IDW(IW), .ACC_W(ACC)) dut (
    .clk(clk), .rst(rst), .en(en), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_clr(req_clr), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_id(rsp_id),
    .rsp_acc(rsp_acc), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int a; int b; bit clr; int due; } op_t;
  typedef struct { int cyc; int id; int acc; bit ovf; } obs_t;
  typedef struct { int cyc; int id; } gnt_t;

  op_t  pend[$];
  obs_t obs[$];
  gnt_t alog[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;
  bit prev_rst = 1'b0;

  longint m_acc [NQ];
  bit     m_ovf [NQ];
  int     m_ptr;
  int     eg, idx, bz;
  logic [NQ-1:0] erdy;
  op_t    o;
  longint exact, wr;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    longint m, w;
    m = longint'(1) << ACC;
    w = x % m;
    if (w < 0) w += m;
    if (w >= m / 2) w -= m;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < NQ; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    m_ptr = 0;
  end

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      eg = -1;
      if (!rst && en)
        for (int k = 0; k < NQ; k++) begin
          idx = (m_ptr + k) % NQ;
          if (eg < 0 && req_vld[idx]) eg = idx;
        end
      erdy = (eg >= 0) ? (NQ'(1) << eg) : '0;
      chk("req_rdy", longint'(req_rdy), longint'(erdy));

      if (rsp_vld) obs.push_back('{cyc, int'(rsp_id), int'(rsp_acc), rsp_ovf});

      if (pend.size() > 0 && pend[0].due == cyc) begin
        o = pend.pop_front();
        exact = (o.clr ? 0 : m_acc[o.id]) + longint'(o.a * o.b);
        wr = wrap(exact);
        m_acc[o.id] = wr;
        m_ovf[o.id] = o.clr ? 1'b0 : (m_ovf[o.id] | (exact != wr));
        chk("rsp_vld", longint'(rsp_vld), 1);
        chk("rsp_id", longint'(rsp_id), o.id);
        chk("rsp_acc", longint'(rsp_acc), wr);
        chk("rsp_ovf", longint'(rsp_ovf), longint'(m_ovf[o.id]));
      end else begin
        chk("rsp_vld_idle", longint'(rsp_vld), 0);
      end

      if (prev_rst) begin
        chk("rst_rsp_id", longint'(rsp_id), 0);
        chk("rst_rsp_acc", longint'(rsp_acc), 0);
        chk("rst_rsp_ovf", longint'(rsp_ovf), 0);
      end

      bz = 0;
      foreach (pend[i]) if (pend[i].due == cyc + 1 || pend[i].due == cyc + 2) bz = 1;
      chk("busy", longint'(busy), bz);

      if (rst) begin
        pend.delete();
        for (int i = 0; i < NQ; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
        m_ptr = 0;
      end else if (eg >= 0) begin
        pend.push_back('{eg, int'($signed(req_a[8*eg +: 8])), int'($signed(req_b[8*eg +: 8])),
                         req_clr[eg], cyc + 3});
        alog.push_back('{cyc, eg});
        m_ptr = (eg + 1) % NQ;
      end
      prev_rst = rst;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic op1(input int id, input int a, input int b, input bit c);
    req_vld = NQ'(1) << id;
    req_a[8*id +: 8] = a[7:0];
    req_b[8*id +: 8] = b[7:0];
    req_clr[id] = c;
    tick(1);
  endtask

  task automatic restart();
    obs.delete();
    alog.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_vld = '0; req_a = '0; req_b = '0; req_clr = '0;
    tick(2);
    chk_on = 1'b1;
    tick(1);
    rst = 1'b0; en = 1'b1;

    // Single op: 3*5 with clear on requester 0.
    restart();
    op1(0, 3, 5, 1'b1);
    req_vld = '0;
    tick(5);
    chk("t1_ngnt", alog.size(), 1);
    chk("t1_nrsp", obs.size(), 1);
    if (obs.size() == 1 && alog.size() == 1) begin
      chk("t1_lat", obs[0].cyc - alog[0].cyc, 3);
      chk("t1_id", obs[0].id, 0);
      chk("t1_acc", obs[0].acc, 15);
    end

    // All requesters valid: grants rotate 0,1,2,3 and responses follow in order.
    rst = 1'b1; tick(1); rst = 1'b0;
    restart();
    req_vld = '1; req_clr = '0;
    for (int k = 0; k < 8; k++) begin
      req_a = $urandom; req_b = $urandom;
      tick(1);
    end
    req_vld = '0;
    tick(5);
    chk("t2_ngnt", alog.size(), 8);
    chk("t2_nrsp", obs.size(), 8);
    if (alog.size() == 8 && obs.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk("t2_gnt", alog[k].id, k % 4);
        chk("t2_rid", obs[k].id, k % 4);
        chk("t2_lat", obs[k].cyc - alog[k].cyc, 3);
      end

    // Back-to-back on requester 2 including the -128*-128 corner.
    restart();
    op1(2, -128, -128, 1'b1);
    op1(2, 127, -128, 1'b0);
    op1(2, 0, 5, 1'b0);
    req_vld = '0;
    tick(5);
    chk("t3_nrsp", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t3_acc0", obs[0].acc, 16384);
      chk("t3_acc1", obs[1].acc, 128);
      chk("t3_acc2", obs[2].acc, 128);
    end

    // 16-bit accumulator: 16129 x3 wraps to -17149 with sticky ovf, cleared by a clr op.
    restart();
    op1(1, 127, 127, 1'b1);
    op1(1, 127, 127, 1'b0);
    op1(1, 127, 127, 1'b0);
    op1(1, 0, 0, 1'b0);
    op1(1, 1, 1, 1'b1);
    req_vld = '0; req_clr = '0;
    tick(5);
    chk("t4_nrsp", obs.size(), 5);
    if (obs.size() == 5) begin
      chk("t4_acc1", obs[1].acc, 32258);
      chk("t4_ovf1", obs[1].ovf, 0);
      chk("t4_acc2", obs[2].acc, -17149);
      chk("t4_ovf2", obs[2].ovf, 1);
      chk("t4_ovf3", obs[3].ovf, 1);
      chk("t4_acc4", obs[4].acc, 1);
      chk("t4_ovf4", obs[4].ovf, 0);
    end

    // en dropped with two ops in flight: no grants, both responses still arrive.
    restart();
    op1(0, 2, 2, 1'b1);
    op1(0, 3, 3, 1'b0);
    en = 1'b0;
    tick(4);
    en = 1'b1; req_vld = '0;
    tick(2);
    chk("t5_ngnt", alog.size(), 2);
    chk("t5_nrsp", obs.size(), 2);
    if (obs.size() == 2) chk("t5_acc", obs[1].acc, 13);

    // Reset with S1 and S2 occupied: both ops vanish, ptr and accumulators restart.
    restart();
    op1(3, 2, 3, 1'b0);
    op1(3, 4, 5, 1'b0);
    req_vld = '0;
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(4);
    chk("t6_nrsp", obs.size(), 0);
    restart();
    req_vld = '1; req_a = {4{8'd1}}; req_b = {4{8'd1}}; req_clr = '0;
    tick(1);
    req_vld = '0;
    tick(4);
    chk("t6_ngnt", alog.size(), 1);
    chk("t6_nrsp", obs.size(), 1);
    if (alog.size() == 1 && obs.size() == 1) begin
      chk("t6_gnt", alog[0].id, 0);
      chk("t6_acc", obs[0].acc, 1);
    end

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 9) != 0);
      req_vld = NQ'($urandom_range(0, 15));
      req_a   = $urandom;
      req_b   = $urandom;
      for (int i = 0; i < NQ; i++) req_clr[i] = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    rst = 1'b0; req_vld = '0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
